// File: rtl/ram_2p_arb.sv
// Two-port arbitrated single-bank RAM with a fixed-latency, in-order response pipeline.
// Define RAM_PARITY_EN to store one even-parity bit per byte and flag mismatches on reads.
module ram_2p_arb #(
    parameter int DW      = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    output logic [1:0]          gnt,
    input  logic [1:0]          we,
    input  logic [2*DW/8-1:0]   be,
    input  logic [63:0]         addr,
    input  logic [2*DW-1:0]     wdata,
    output logic [1:0]          rvalid,
    output logic [2*DW-1:0]     rdata,
    output logic [1:0]          err
);

    localparam int NB = DW / 8;
    localparam int BO = $clog2(NB);
    localparam int AW = $clog2(DEPTH);

    logic            ptr;
    logic            acc;
    logic            sel;
    logic [31:0]     a_sel;
    logic [DW-1:0]   wd_sel;
    logic [NB-1:0]   be_sel;
    logic            we_sel;
    logic [AW-1:0]   idx;
    logic            oor;
    logic [DW-1:0]   rd_word;
    logic            par_bad;
    logic            s_err;
    logic [DW-1:0]   s_data;
    logic            unused_addr_bits;

    logic [DW-1:0]   mem [DEPTH];

    logic            pv [LATENCY];
    logic            pp [LATENCY];
    logic            pe [LATENCY];
    logic [DW-1:0]   pd [LATENCY];

    // Grants are forced low while in reset so nothing can be accepted.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (req == 2'b11)
            ptr <= ~ptr;
    end

    assign acc    = |gnt;
    assign sel    = gnt[1];
    assign a_sel  = sel ? addr[63:32] : addr[31:0];
    assign wd_sel = sel ? wdata[2*DW-1:DW] : wdata[DW-1:0];
    assign be_sel = sel ? be[2*NB-1:NB] : be[NB-1:0];
    assign we_sel = sel ? we[1] : we[0];

    assign idx              = a_sel[BO +: AW];
    assign oor              = (a_sel >> (BO + AW)) != 32'd0;
    assign unused_addr_bits = &{1'b0, a_sel[BO-1:0]};

    always_ff @(posedge clk) begin
        if (acc && we_sel && !oor) begin
            for (int i = 0; i < NB; i++) begin
                if (be_sel[i])
                    mem[idx][8*i +: 8] <= wd_sel[8*i +: 8];
            end
        end
    end

    assign rd_word = mem[idx];

`ifdef RAM_PARITY_EN
    logic [NB-1:0] par [DEPTH];

    always_ff @(posedge clk) begin
        if (acc && we_sel && !oor) begin
            for (int i = 0; i < NB; i++) begin
                if (be_sel[i])
                    par[idx][i] <= ^wd_sel[8*i +: 8];
            end
        end
    end

    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if ((^rd_word[8*i +: 8]) != par[idx][i])
                par_bad = 1'b1;
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    // Write responses and out-of-range accesses carry zero data.
    assign s_err  = oor | (!we_sel & par_bad);
    assign s_data = (!we_sel && !oor) ? rd_word : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                pv[i] <= 1'b0;
                pp[i] <= 1'b0;
                pe[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= acc;
            pp[0] <= sel;
            pe[0] <= acc & s_err;
            pd[0] <= acc ? s_data : '0;
            for (int i = 1; i < LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pp[i] <= pp[i-1];
                pe[i] <= pe[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    always_comb begin
        rvalid = 2'b00;
        err    = 2'b00;
        rdata  = '0;
        if (pv[LATENCY-1]) begin
            if (pp[LATENCY-1]) begin
                rvalid[1]          = 1'b1;
                err[1]             = pe[LATENCY-1];
                rdata[2*DW-1:DW]   = pd[LATENCY-1];
            end else begin
                rvalid[0]          = 1'b1;
                err[0]             = pe[LATENCY-1];
                rdata[DW-1:0]      = pd[LATENCY-1];
            end
        end
    end

endmodule

// File: tb/tb_ram_2p_arb.sv
// Directed + random bench for ram_2p_arb (DW=32, DEPTH=1024, LATENCY=3) with a response scoreboard.
module tb_ram_2p_arb;
    localparam int DW  = 32;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  gnt;
    logic [1:0]  we = 2'b00;
    logic [7:0]  be = 8'h00;
    logic [63:0] addr = 64'd0;
    logic [63:0] wdata = 64'd0;
    logic [1:0]  rvalid;
    logic [63:0] rdata;
    logic [1:0]  err;

    ram_2p_arb #(.DW(DW), .DEPTH(1024), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .we(we), .be(be),
        .addr(addr), .wdata(wdata), .rvalid(rvalid), .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [1024];
    logic [3:0]  mdl_bad [1024];
    logic        ptr_m = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Response monitor: pops the scoreboard whenever a port presents rvalid.
    exp_t m_e;
    always @(negedge clk) begin
        chk("rvalid_both_ports", 64'(rvalid == 2'b11), 64'd0);
        for (int p = 0; p < 2; p++) begin
            if (rvalid[p]) begin
                chk("sb_nonempty_at_rvalid", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    m_e = sb.pop_front();
                    chk("resp_port",  64'(p),   64'(m_e.port));
                    chk("resp_cycle", 64'(cyc), 64'(m_e.due));
                    chk("resp_err",   64'(err[p]), 64'(m_e.err));
                    chk("resp_data",  64'(p == 1 ? rdata[63:32] : rdata[31:0]), 64'(m_e.data));
                end
            end
        end
        if (rvalid == 2'b00 && sb.size() != 0)
            chk("missing_rvalid", 64'(sb[0].due > cyc), 64'd1);
    end

    // One cycle of stimulus; called at a falling edge, returns at the next one.
    task automatic step(input logic [1:0] r, input logic [1:0] w, input logic [7:0] b,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
        logic [1:0]  eg;
        int          p;
        logic [31:0] ap, dp;
        logic [3:0]  bp;
        logic        oor;
        int          idx;
        exp_t        e;
        req = r; we = w; be = b; addr = {a1, a0}; wdata = {d1, d0};
        #1;
        case (r)
            2'b01:   eg = 2'b01;
            2'b10:   eg = 2'b10;
            2'b11:   eg = ptr_m ? 2'b10 : 2'b01;
            default: eg = 2'b00;
        endcase
        chk("gnt", 64'(gnt), 64'(eg));
        if (eg != 2'b00) begin
            p   = eg[1] ? 1 : 0;
            ap  = (p == 1) ? a1 : a0;
            dp  = (p == 1) ? d1 : d0;
            bp  = (p == 1) ? b[7:4] : b[3:0];
            oor = ap[31:12] != 20'd0;
            idx = int'(ap[11:2]);
            e.port = p; e.due = cyc + LAT; e.err = oor; e.data = 32'd0;
            if (w[p]) begin
                if (!oor) begin
                    for (int i = 0; i < 4; i++) begin
                        if (bp[i]) begin
                            mdl[idx][8*i +: 8] = dp[8*i +: 8];
                            mdl_bad[idx][i] = 1'b0;
                        end
                    end
                end
            end else if (!oor) begin
                e.data = mdl[idx];
                e.err  = |mdl_bad[idx];
            end
            sb.push_back(e);
            if (r == 2'b11) ptr_m = ~ptr_m;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, 8'h00, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [1:0]  r, w;
        logic [31:0] a0, a1;
        for (int i = 0; i < 1024; i++) begin
            mdl[i] = 32'd0;
            mdl_bad[i] = 4'd0;
        end

        // Reset state with both ports requesting.
        req = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_gnt",    64'(gnt),    64'd0);
        chk("reset_rvalid", 64'(rvalid), 64'd0);
        chk("reset_rdata",  rdata,       64'd0);
        chk("reset_err",    64'(err),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First cycle after release: write, then read back.
        step(2'b01, 2'b01, 8'h0F, 32'h10, 32'h0, 32'hA5A5A5A5, 32'h0);
        step(2'b01, 2'b00, 8'h00, 32'h10, 32'h0, 32'h0, 32'h0);
        // Partial byte write, read immediately after.
        step(2'b10, 2'b10, 8'hF0, 32'h0, 32'h20, 32'h0, 32'h11223344);
        step(2'b10, 2'b10, 8'h20, 32'h0, 32'h20, 32'h0, 32'hFFFFFFFF);
        step(2'b01, 2'b00, 8'h00, 32'h20, 32'h0, 32'h0, 32'h0);
        chk("partial_write_word", 64'(mdl[8]), 64'h1122FF44);
        // Contested reads alternate 0,1,0,1.
        repeat (4) step(2'b11, 2'b00, 8'h00, 32'h10, 32'h20, 32'h0, 32'h0);
        // Out of range reads and writes.
        step(2'b01, 2'b01, 8'h0F, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0);
        step(2'b01, 2'b00, 8'h00, 32'h1000, 32'h0, 32'h0, 32'h0);
        step(2'b10, 2'b10, 8'hF0, 32'h0, 32'h1000, 32'h0, 32'h0BAD0BAD);
        step(2'b01, 2'b00, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
        idle(LAT + 2);

        // Fill words 0..15 then random traffic.
        for (int i = 0; i < 16; i++)
            step((i % 2 == 1) ? 2'b10 : 2'b01, 2'b11, 8'hFF, 32'(i * 4), 32'(i * 4),
                 $urandom, $urandom);
        repeat (60) begin
            r  = 2'($urandom_range(0, 3));
            w  = 2'($urandom_range(0, 3));
            a0 = 32'($urandom_range(0, 15) * 4);
            a1 = 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) a0 = a0 | 32'h0001_0000;
            if ($urandom_range(0, 7) == 0) a1 = a1 | 32'h0000_4000;
            step(r, w, 8'($urandom), a0, a1, $urandom, $urandom);
        end
        idle(LAT + 2);

        // Reset with reads in flight: nothing may come back.
        step(2'b01, 2'b00, 8'h00, 32'h10, 32'h0, 32'h0, 32'h0);
        step(2'b01, 2'b00, 8'h00, 32'h14, 32'h0, 32'h0, 32'h0);
        req = 2'b01; we = 2'b00; addr = {32'h0, 32'h18};
        #2;
        rst_n = 1'b0;
        sb.delete();
        ptr_m = 1'b0;
        #1;
        chk("midreset_gnt",    64'(gnt),    64'd0);
        chk("midreset_rvalid", 64'(rvalid), 64'd0);
        chk("midreset_rdata",  rdata,       64'd0);
        chk("midreset_err",    64'(err),    64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("inreset_rvalid", 64'(rvalid), 64'd0);
            chk("inreset_gnt",    64'(gnt),    64'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            idle(1);
            chk("post_reset_rvalid", 64'(rvalid), 64'd0);
            chk("post_reset_rdata",  rdata,       64'd0);
        end
        // Pointer back at port 0 after reset.
        step(2'b11, 2'b00, 8'h00, 32'h10, 32'h20, 32'h0, 32'h0);
        idle(LAT + 2);

`ifdef RAM_PARITY_EN
        step(2'b01, 2'b01, 8'h0F, 32'h40, 32'h0, 32'h0, 32'h0);
        idle(1);
        dut.mem[16] = dut.mem[16] ^ 32'h8;
        mdl[16] = mdl[16] ^ 32'h8;
        mdl_bad[16][0] = 1'b1;
        step(2'b01, 2'b00, 8'h00, 32'h40, 32'h0, 32'h0, 32'h0);
        idle(LAT + 2);
`endif

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got cycle %0d want completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
